// File: rtl/updown_sweep_ctrl_if.sv
// Control bus between the sweep sequencer and the loadable up/down counter.
// The sequencer is the master; the counter drives back its current value.
interface updown_sweep_ctrl_if #(
    parameter int BITS = 4
) ();
    logic            cnt_load;
    logic            cnt_up;
    logic            cnt_enable;
    logic [BITS-1:0] cnt_d;
    logic [BITS-1:0] cnt_q;

    modport master (
        output cnt_load,
        output cnt_up,
        output cnt_enable,
        output cnt_d,
        input  cnt_q
    );

    modport slave (
        input  cnt_load,
        input  cnt_up,
        input  cnt_enable,
        input  cnt_d,
        output cnt_q
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for the loadable up/down counter.
// Steps lo..hi..lo at a prescaled rate for a programmed number of sweeps.
module updown_sweep_ctrl #(
    parameter int BITS    = 4,
    parameter int PRESC_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [BITS-1:0]     lo,
    input  logic [BITS-1:0]     hi,
    input  logic [3:0]          sweeps,
    input  logic [PRESC_W-1:0]  presc,
    updown_sweep_ctrl_if.master cnt,
    output logic                busy,
    output logic                done,
    output logic [3:0]          sweep_cnt,
    output logic                err
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t             state;
    logic [BITS-1:0]    lo_r;
    logic [BITS-1:0]    hi_r;
    logic [3:0]         sweeps_r;
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] pcnt;
    logic               up_r;
    logic               stepping;
    logic               tick;
    logic               top_step;
    logic               bot_step;
    logic [3:0]         sweep_nx;

    assign stepping = (state == UP) || (state == DOWN);
    assign tick     = stepping && (pcnt == presc_r);
    assign top_step = cnt.cnt_q == hi_r - BITS'(1);
    assign bot_step = cnt.cnt_q == lo_r + BITS'(1);
    assign sweep_nx = sweep_cnt + 4'd1;

    // abort is the only input allowed to reach the counter controls directly
    assign cnt.cnt_load   = (state == LOAD) && !abort;
    assign cnt.cnt_enable = !abort && ((state == LOAD) || tick);
    assign cnt.cnt_up     = up_r;
    assign cnt.cnt_d      = lo_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            sweeps_r  <= '0;
            presc_r   <= '0;
            pcnt      <= '0;
            up_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (lo < hi) begin
                            lo_r      <= lo;
                            hi_r      <= hi;
                            sweeps_r  <= (sweeps == 4'd0) ? 4'd1 : sweeps;
                            presc_r   <= presc;
                            sweep_cnt <= '0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    pcnt <= '0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        up_r  <= 1'b1;
                        state <= UP;
                    end
                end
                UP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        up_r  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        pcnt <= '0;
                        if (top_step) begin
                            up_r  <= 1'b0;
                            state <= DOWN;
                        end
                    end else begin
                        pcnt <= pcnt + PRESC_W'(1);
                    end
                end
                DOWN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        pcnt <= '0;
                        if (bot_step) begin
                            sweep_cnt <= sweep_nx;
                            if (sweep_nx == sweeps_r) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                up_r  <= 1'b1;
                                state <= UP;
                            end
                        end
                    end else begin
                        pcnt <= pcnt + PRESC_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: behavioural counter, vector table,
// directed abort/reset sequences and randomized runs vs a trace model.
module tb_updown_sweep_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] sweeps;
    logic [7:0] presc;
    logic       busy;
    logic       done;
    logic [3:0] sweep_cnt;
    logic       err;
    logic [3:0] q;

    int checks = 0;
    int errors = 0;
    int q_prev;
    int exp_sc;

    typedef struct packed {
        int lo;
        int hi;
        int sweeps;
        int presc;
        int err;
        int done_at;
        int sc;
    } vec_t;

    vec_t tbl [8];

    updown_sweep_ctrl_if #(.BITS(4)) cif ();

    updown_sweep_ctrl #(
        .BITS(4),
        .PRESC_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .lo(lo),
        .hi(hi),
        .sweeps(sweeps),
        .presc(presc),
        .cnt(cif),
        .busy(busy),
        .done(done),
        .sweep_cnt(sweep_cnt),
        .err(err)
    );

    // the loadable up/down counter the sequencer drives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (cif.cnt_enable) begin
            if (cif.cnt_load) q <= cif.cnt_d;
            else if (cif.cnt_up) q <= q + 4'd1;
            else q <= q - 4'd1;
        end
    end
    assign cif.cnt_q = q;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One run: cycle c counts from the edge that samples start.
    // Expected trace comes from step arithmetic over the triangle.
    task automatic do_run(input int l, input int h, input int s, input int p,
                          input int ab, output int done_at, output int ndone);
        int n, se, pp, tot, last, k, st, si;
        int b, d, ld, en, up, cq, csc;
        done_at = 0;
        ndone = 0;
        @(posedge clk); #1;
        lo = 4'(l);
        hi = 4'(h);
        sweeps = 4'(s);
        presc = 8'(p);
        start = 1'b1;
        abort = 1'b0;
        if (l >= h) begin
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                chk("cfg_err", int'(err), 1);
                chk("cfg_busy", int'(busy), 0);
                chk("cfg_load", int'(cif.cnt_load), 0);
                chk("cfg_enable", int'(cif.cnt_enable), 0);
                chk("cfg_done", int'(done), 0);
                chk("cfg_sweep_cnt", int'(sweep_cnt), exp_sc);
                chk("cfg_cnt_q", int'(cif.cnt_q), q_prev);
                if (done) ndone++;
            end
            return;
        end
        n = h - l;
        se = (s == 0) ? 1 : s;
        pp = p + 1;
        tot = 1 + 2 * n * se * pp;
        last = (ab > 0) ? ab + 1 : tot + 2;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            lo = 4'($urandom_range(0, 15));
            hi = 4'($urandom_range(0, 15));
            sweeps = 4'($urandom_range(0, 15));
            presc = 8'($urandom_range(0, 255));
            abort = (c == ab);
            b = 0; d = 0; ld = 0; en = 0; up = 0;
            if (ab > 0 && c == ab + 1) begin
                cq = q_prev;
                csc = exp_sc;
            end else if (c == 1) begin
                b = 1; ld = 1; en = 1;
                cq = q_prev;
                csc = 0;
            end else if (c <= tot) begin
                k = c - 2;
                st = k / pp;
                si = st % (2 * n);
                cq = l + ((si <= n) ? si : 2 * n - si);
                up = (si < n) ? 1 : 0;
                en = (k % pp == pp - 1) ? 1 : 0;
                csc = st / (2 * n);
                b = 1;
            end else begin
                d = (c == tot + 1) ? 1 : 0;
                cq = l;
                csc = se;
            end
            if (c == ab) begin
                en = 0;
                ld = 0;
            end
            q_prev = cq;
            exp_sc = csc;
            @(negedge clk);
            chk("busy", int'(busy), b);
            chk("done", int'(done), d);
            chk("cnt_load", int'(cif.cnt_load), ld);
            chk("cnt_enable", int'(cif.cnt_enable), en);
            chk("cnt_up", int'(cif.cnt_up), up);
            chk("cnt_q", int'(cif.cnt_q), cq);
            chk("cnt_d", int'(cif.cnt_d), l);
            chk("sweep_cnt", int'(sweep_cnt), csc);
            chk("err", int'(err), 0);
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
        end
    endtask

    initial begin
        int da, nd;
        reset_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lo = '0;
        hi = '0;
        sweeps = '0;
        presc = '0;
        q_prev = 0;
        exp_sc = 0;
        tbl[0] = '{2, 5, 1, 0, 0, 8, 1};
        tbl[1] = '{0, 2, 1, 3, 0, 18, 1};
        tbl[2] = '{1, 3, 3, 0, 0, 14, 3};
        tbl[3] = '{1, 3, 0, 0, 0, 6, 1};
        tbl[4] = '{5, 5, 1, 0, 1, 0, 1};
        tbl[5] = '{4, 5, 1, 0, 0, 4, 1};
        tbl[6] = '{9, 3, 2, 1, 1, 0, 1};
        tbl[7] = '{0, 15, 2, 0, 0, 62, 2};

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sweep_cnt", int'(sweep_cnt), 0);
        chk("rst_load", int'(cif.cnt_load), 0);
        chk("rst_enable", int'(cif.cnt_enable), 0);
        chk("rst_up", int'(cif.cnt_up), 0);
        chk("rst_cnt_d", int'(cif.cnt_d), 0);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i].lo, tbl[i].hi, tbl[i].sweeps, tbl[i].presc, 0, da, nd);
            chk("tbl_done_at", da, tbl[i].done_at);
            chk("tbl_ndone", nd, (tbl[i].err != 0) ? 0 : 1);
            chk("tbl_err", int'(err), tbl[i].err);
            chk("tbl_sweep_cnt", int'(sweep_cnt), tbl[i].sc);
        end

        // abort on the way down at cnt_q=6; stray starts fall inside the run
        do_run(0, 9, 1, 0, 14, da, nd);
        chk("abort_ndone", nd, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_q", int'(cif.cnt_q), 6);
            chk("abort_idle_busy", int'(busy), 0);
            chk("abort_idle_enable", int'(cif.cnt_enable), 0);
        end

        // reset clears a sticky err while idle
        do_run(7, 2, 1, 0, 0, da, nd);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_idle_err", int'(err), 0);
        @(posedge clk); #3 reset_n = 1'b1;

        // reset dropped between edges in the middle of a run
        @(posedge clk); #1;
        lo = 4'd3; hi = 4'd4; sweeps = 4'd3; presc = 8'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_sweep_cnt", int'(sweep_cnt), 1);
        chk("mid_busy", int'(busy), 1);
        chk("mid_up", int'(cif.cnt_up), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_enable", int'(cif.cnt_enable), 0);
        chk("arst_up", int'(cif.cnt_up), 0);
        chk("arst_load", int'(cif.cnt_load), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_sweep_cnt", int'(sweep_cnt), 0);
        @(posedge clk); #3 reset_n = 1'b1;
        q_prev = 0;
        exp_sc = 0;
        do_run(2, 6, 1, 1, 0, da, nd);
        chk("post_rst_done_at", da, 18);

        for (int i = 0; i < 40; i++) begin
            int l, h, s, p, n, se, tot, ab, t;
            l = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            if (l > h && $urandom_range(0, 3) != 0) begin
                t = l; l = h; h = t;
            end
            s = $urandom_range(0, 3);
            p = $urandom_range(0, 3);
            ab = 0;
            if (l < h && $urandom_range(0, 3) == 0) begin
                n = h - l;
                se = (s == 0) ? 1 : s;
                tot = 1 + 2 * n * se * (p + 1);
                ab = $urandom_range(1, tot);
            end
            do_run(l, h, s, p, ab, da, nd);
            chk("rnd_ndone", nd, (l < h && ab == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
